// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding
// and the bit-counter width function.
package serial_adder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Wide enough to hold WIDTH-1 without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder composed of two half adders with an OR on the carries.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    half_adder u_ha1 (
        .a     (s0),
        .b     (cin),
        .sum   (sum),
        .carry (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder, the base cell of the adder family.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH-bit operands, one bit per clock, LSB first.
// Define SERIAL_ADDER_CIN_EN to add a carry-in port sampled with the operands.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic             cin,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] r_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             carry_init;
    logic             s;
    logic             c_nxt;
    logic             last;

`ifdef SERIAL_ADDER_CIN_EN
    assign carry_init = cin;
`else
    assign carry_init = 1'b0;
`endif

    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (s),
        .cout (c_nxt)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == ST_SHIFT);

    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the operand/result shift registers are reset as well, so an aborted
    // add leaves no stale bits behind; they are flops, not a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            r_sr    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= carry_init;
                        cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    carry <= c_nxt;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    // New bit enters at the top; after WIDTH shifts bit 0 sits at the LSB.
                    r_sr  <= (WIDTH-1)'({s, r_sr} >> 1);
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum_out <= {s, r_sr};
                        cout    <= c_nxt;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with a result scoreboard.
// Define SERIAL_ADDER_CIN_EN to also exercise the carry-in build.
module tb_serial_adder;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             co;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
`ifdef SERIAL_ADDER_CIN_EN
    logic             cin;
`endif
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;

    int               vectors = 0;
    int               miscompares = 0;
    exp_t             sb[$];
    logic [WIDTH-1:0] held_sum = '0;
    logic             held_cout = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
`ifdef SERIAL_ADDER_CIN_EN
        .cin     (cin),
`endif
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c);
        logic [WIDTH:0] t;
        exp_t e;
        t = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        e.sum = t[WIDTH-1:0];
        e.co  = t[WIDTH];
        return e;
    endfunction

    // Drive one start pulse; the edge consumed here is edge k.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input bit push);
        a_in  = a;
        b_in  = b;
`ifdef SERIAL_ADDER_CIN_EN
        cin   = c;
`endif
        start = 1'b1;
        if (push) sb.push_back(model(a, b, c));
        tick();
        start = 1'b0;
    endtask

    // Cycles k..k+WIDTH-1: busy, no done, outputs held.
    task automatic run_busy(input string tag);
        for (int i = 0; i < WIDTH; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_hold_sum"}, 32'(sum_out), 32'(held_sum));
            check({tag, "_hold_cout"}, 32'(cout), 32'(held_cout));
            tick();
        end
    endtask

    // Cycle after edge k+WIDTH: done pulse and result against the scoreboard.
    task automatic check_done(input string tag);
        exp_t e;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_sum"}, 32'(sum_out), 32'(e.sum));
            check({tag, "_cout"}, 32'(cout), 32'(e.co));
            held_sum  = e.sum;
            held_cout = e.co;
        end
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_q_done"}, 32'(done), 32'd0);
            check({tag, "_q_busy"}, 32'(busy), 32'd0);
            tick();
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
`ifdef SERIAL_ADDER_CIN_EN
        cin   = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_sum", 32'(sum_out), 32'd0);
            check("rst_cout", 32'(cout), 32'd0);
            tick();
        end

        // Basic add.
        launch(8'h5A, 8'h3C, 1'b0, 1'b1);
        run_busy("add5a");
        check_done("add5a");
        tick();
        check("add5a_pulse_end", 32'(done), 32'd0);
        quiet("add5a", 2);

        // Overflow, then back-to-back start in the done cycle.
        launch(8'hFF, 8'h01, 1'b0, 1'b1);
        run_busy("ovf");
        check_done("ovf");
        launch(8'hFF, 8'hFF, 1'b0, 1'b1);
        run_busy("b2b");
        check_done("b2b");
        tick();
        check("b2b_pulse_end", 32'(done), 32'd0);
        quiet("b2b", 2);

        // Start while busy is ignored.
        launch(8'h10, 8'h20, 1'b0, 1'b1);
        for (int i = 0; i < WIDTH; i++) begin
            check("ign_busy", 32'(busy), 32'd1);
            check("ign_nodone", 32'(done), 32'd0);
            if (i == 2) begin
                a_in  = 8'h77;
                b_in  = 8'h77;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check_done("ign");
        tick();
        quiet("ign", WIDTH + 3);

        // Reset mid-operation aborts without a done pulse.
        launch(8'hAA, 8'h55, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum_out), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        quiet("abort", WIDTH + 2);
        launch(8'h01, 8'h01, 1'b0, 1'b1);
        run_busy("post_rst");
        check_done("post_rst");
        tick();

`ifdef SERIAL_ADDER_CIN_EN
        launch(8'hFF, 8'h00, 1'b1, 1'b1);
        run_busy("cin1");
        check_done("cin1");
        tick();
        launch(8'hFF, 8'h00, 1'b0, 1'b1);
        run_busy("cin0");
        check_done("cin0");
        tick();
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
